// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: shared state encoding and width helpers for the SPI burst memory.
package spi_mem_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA_WR, DATA_RD} state_t;

    function automatic int cnt_w(input int aw, input int dw);
        int m;
        m = (aw + 1 > dw) ? aw + 1 : dw;
        return (m > 2) ? $clog2(m) : 1;
    endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser with one-clk rise/fall pulses on the synchronised level.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;
endmodule

// File: rtl/spi_memory_burst.sv
// spi_memory_burst: SPI slave (mode 3 style, LSB-first address, MSB-first data) fronting a
// single-port synchronous RAM with optional auto-increment bursts.
module spi_memory_burst import spi_mem_pkg::*; #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int BURST_EN    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_pin,
    input  logic       cs_pin,
    output logic       miso_pin,
    input  logic       mosi_pin,
    output logic [3:0] leds
);
    localparam int CW = cnt_w(ADDR_W, DATA_W);
    localparam logic [CW-1:0] A_LAST = CW'(ADDR_W);
    localparam logic [CW-1:0] D_LAST = CW'(DATA_W - 1);

    logic sclk_rise, sclk_fall, cs_s, cs_fall, mosi_s;
    logic unused_sclk, unused_cs_rise, unused_mosi_rise, unused_mosi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk_pin),
        .dout(unused_sclk), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst_n(rst_n), .din(cs_pin),
        .dout(cs_s), .rise(unused_cs_rise), .fall(cs_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .din(mosi_pin),
        .dout(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall));

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, mem_addr;
    logic [DATA_W-1:0]   sh_q, sh_d, rd_q, rd_d, wdata, rdata_q;
    logic                miso_q, miso_d, done_q, done_d, ld_q, ld_d;
    logic [3:0]          leds_q, leds_d;
    logic                we, re, nxt;
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    assign wdata    = {sh_q[DATA_W-2:0], mosi_s};
    assign mem_addr = nxt ? addr_q + ADDR_W'(1) : addr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        sh_d    = sh_q;
        rd_d    = ld_q ? rdata_q : rd_q;
        miso_d  = miso_q;
        done_d  = done_q;
        leds_d  = leds_q;
        ld_d    = 1'b0;
        we      = 1'b0;
        re      = 1'b0;
        nxt     = 1'b0;
        if (cs_s) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
            sh_d    = '0;
        end else begin
            case (state_q)
                IDLE: if (cs_fall) begin
                    state_d = ADDR;
                    cnt_d   = '0;
                end
                ADDR: if (sclk_rise) begin
                    if (cnt_q == A_LAST) begin
                        state_d = mosi_s ? DATA_RD : DATA_WR;
                        cnt_d   = '0;
                        re      = mosi_s;
                    end else begin
                        addr_d = {mosi_s, addr_q[ADDR_W-1:1]};
                        cnt_d  = cnt_q + CW'(1);
                    end
                end
                DATA_WR: if (sclk_rise && !done_q) begin
                    sh_d = wdata;
                    if (cnt_q == D_LAST) begin
                        we     = 1'b1;
                        leds_d = wdata[3:0];
                        cnt_d  = '0;
                        addr_d = (BURST_EN != 0) ? addr_q + ADDR_W'(1) : addr_q;
                        done_d = (BURST_EN == 0);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DATA_RD: if (!done_q) begin
                    if (sclk_fall) begin
                        miso_d = rd_q[DATA_W-1];
                        rd_d   = {rd_q[DATA_W-2:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        if (cnt_q == D_LAST) begin
                            cnt_d  = '0;
                            re     = (BURST_EN != 0);
                            nxt    = (BURST_EN != 0);
                            addr_d = (BURST_EN != 0) ? addr_q + ADDR_W'(1) : addr_q;
                            done_d = (BURST_EN == 0);
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        ld_d = re;
        // miso only ever carries data while an unfinished read is in progress
        if (state_d != DATA_RD || done_d)
            miso_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            sh_q    <= '0;
            rd_q    <= '0;
            miso_q  <= 1'b0;
            done_q  <= 1'b0;
            ld_q    <= 1'b0;
            leds_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            sh_q    <= sh_d;
            rd_q    <= rd_d;
            miso_q  <= miso_d;
            done_q  <= done_d;
            ld_q    <= ld_d;
            leds_q  <= leds_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[mem_addr] <= wdata;
        else if (re)
            rdata_q <= mem[mem_addr];
    end

    assign miso_pin = miso_q;
    assign leds     = leds_q;
endmodule

// File: tb/tb_spi_memory_burst.sv
// tb_spi_memory_burst: directed SPI frames against a burst and a non-burst instance, scoreboarded reads.
module tb_spi_memory_burst;
    logic clk = 1'b0, rst_n = 1'b0, sclk_pin = 1'b1, cs_pin = 1'b1, mosi_pin = 1'b0;
    logic miso0, miso1;
    logic [3:0] leds0, leds1;
    int cmp_cnt = 0, err_cnt = 0;
    bit tx_q[$];
    logic rx0_q[$], rx1_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    spi_memory_burst #(.BURST_EN(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .sclk_pin(sclk_pin), .cs_pin(cs_pin),
        .miso_pin(miso0), .mosi_pin(mosi_pin), .leds(leds0));
    spi_memory_burst #(.BURST_EN(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .sclk_pin(sclk_pin), .cs_pin(cs_pin),
        .miso_pin(miso1), .mosi_pin(mosi_pin), .leds(leds1));

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hdr(input int a, input bit rw);
        tx_q.delete();
        for (int i = 0; i < 7; i++) tx_q.push_back(a[i]);
        tx_q.push_back(rw);
    endtask

    task automatic add_byte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) tx_q.push_back(d[i]);
    endtask

    task automatic frame(input int nstop);
        rx0_q.delete();
        rx1_q.delete();
        cs_pin = 1'b0;
        half();
        for (int i = 0; i < tx_q.size() && i != nstop; i++) begin
            sclk_pin = 1'b0;
            mosi_pin = tx_q[i];
            half();
            rx0_q.push_back(miso0);
            rx1_q.push_back(miso1);
            sclk_pin = 1'b1;
            half();
        end
        cs_pin   = 1'b1;
        mosi_pin = 1'b0;
        half();
        half();
    endtask

    function automatic logic [7:0] rx_byte(input int which, input int w);
        logic [7:0] v = '0;
        for (int b = 0; b < 8; b++)
            v = {v[6:0], (which == 0) ? rx0_q[8 + 8*w + b] : rx1_q[8 + 8*w + b]};
        return v;
    endfunction

    task automatic wr(input int a, input logic [7:0] d);
        hdr(a, 1'b0);
        add_byte(d);
        frame(-1);
    endtask

    task automatic rd(input int which, input int a, input int n, input string tag);
        hdr(a, 1'b1);
        for (int w = 0; w < n; w++) add_byte(8'h00);
        frame(-1);
        for (int w = 0; w < n; w++) check(tag, rx_byte(which, w), exp_q.pop_front());
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("reset_miso0", {7'd0, miso0}, 8'h00);
        check("reset_leds0", {4'd0, leds0}, 8'h00);
        check("reset_leds1", {4'd0, leds1}, 8'h00);
        rst_n = 1'b1;
        half();

        wr(8'h61, 8'hB1);
        check("wr_leds0", {4'd0, leds0}, 8'h01);
        check("wr_leds1", {4'd0, leds1}, 8'h01);
        exp_q.push_back(8'hB1);
        rd(0, 8'h61, 1, "rd61_dut0");
        exp_q.push_back(8'hB1);
        rd(1, 8'h61, 1, "rd61_dut1");

        hdr(8'h7F, 1'b0);
        add_byte(8'hAA);
        add_byte(8'h55);
        add_byte(8'h3C);
        frame(-1);
        check("burst_leds0", {4'd0, leds0}, 8'h0C);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h3C);
        rd(0, 8'h7F, 3, "burst_wrap_rd");
        exp_q.push_back(8'h55);
        rd(0, 8'h00, 1, "rd00");
        exp_q.push_back(8'h3C);
        rd(0, 8'h01, 1, "rd01");

        hdr(8'h00, 1'b0);
        for (int i = 0; i < 128; i++) add_byte(8'hB3);
        frame(-1);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'hB3);
        rd(0, 8'h78, 16, "fill_burst_rd");

        hdr(8'h10, 1'b0);
        add_byte(8'h82);
        frame(11);
        exp_q.push_back(8'hB3);
        rd(0, 8'h10, 1, "abort_rd10");
        check("abort_leds0", {4'd0, leds0}, 8'h03);

        wr(8'h06, 8'h5A);
        hdr(8'h05, 1'b0);
        add_byte(8'h11);
        add_byte(8'h22);
        frame(-1);
        check("noburst_leds1", {4'd0, leds1}, 8'h01);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h00);
        rd(1, 8'h05, 2, "noburst_rd05");
        exp_q.push_back(8'h5A);
        rd(1, 8'h06, 1, "noburst_rd06");
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        rd(0, 8'h05, 2, "burst_rd05");

        hdr(8'h20, 1'b0);
        add_byte(8'hFF);
        cs_pin = 1'b0;
        half();
        for (int i = 0; i < 12; i++) begin
            sclk_pin = 1'b0;
            mosi_pin = tx_q[i];
            half();
            sclk_pin = 1'b1;
            half();
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso0", {7'd0, miso0}, 8'h00);
        check("rst_leds0", {4'd0, leds0}, 8'h00);
        check("rst_leds1", {4'd0, leds1}, 8'h00);
        cs_pin   = 1'b1;
        mosi_pin = 1'b0;
        half();
        rst_n = 1'b1;
        half();
        exp_q.push_back(8'hB3);
        rd(0, 8'h20, 1, "rst_rd20");
        wr(8'h21, 8'h4D);
        check("post_rst_leds0", {4'd0, leds0}, 8'h0D);
        exp_q.push_back(8'h4D);
        rd(0, 8'h21, 1, "post_rst_rd21");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/spi_memory_burst.md
SPI_MEMORY_BURST -- requirements
Module: spi_memory_burst

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, address bits per frame; memory depth 2^ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 8, bits per memory word.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops on each SPI input (legal 2..4).
REQ-004 SHALL have parameter BURST_EN, default 1; 1 = auto-increment burst enabled, 0 = single word per frame.
REQ-005 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port sclk_pin  input  1  SPI clock, asynchronous to clk, idle high.
REQ-008 SHALL have port cs_pin  input  1  chip select, active-low.
REQ-009 SHALL have port miso_pin  output  1  serial read data.
REQ-010 SHALL have port mosi_pin  input  1  serial command/write data.
REQ-011 SHALL have port leds  output  4  bits [3:0] of the most recently committed write word.

Function
REQ-012 SHALL pass sclk_pin, cs_pin, mosi_pin through SYNC_STAGES flops and derive one-clk sclk rise/fall pulses and a cs fall pulse from synchronised values.
REQ-013 SHALL require sclk high and low phases of at least SYNC_STAGES+3 clk cycles each; faster sclk is out of scope.
REQ-014 SHALL implement states IDLE, ADDR, DATA_WR, DATA_RD.
REQ-015 IDLE -> ADDR on synchronised cs fall; bit counter cleared.
REQ-016 In ADDR, SHALL sample mosi on each sclk rise: first ADDR_W bits form the address LSB first, next bit is R/W (0 write, 1 read).
REQ-017 On the R/W rise: 0 -> DATA_WR; 1 -> DATA_RD, memory read issued at that address.
REQ-018 In DATA_WR, SHALL shift in DATA_W bits MSB first on sclk rises; on the DATA_W-th rise, word written to memory and leds updated exactly 1 clk later.
REQ-019 In DATA_RD, SHALL drive word MSB on miso from the first sclk fall after the R/W rise, next bit on each subsequent fall; miso held between falls.
REQ-020 miso SHALL be 0 in every state other than DATA_RD.
REQ-021 Burst (BURST_EN=1): after each full word with cs still low, address increments by 1 modulo 2^ADDR_W, bit counter clears, state unchanged; in DATA_RD next word fetched on the DATA_W-th rise, its MSB driven on the following fall.
REQ-022 BURST_EN=0: after first full word, SHALL ignore sclk until cs high; no further writes; miso 0.
REQ-023 Synchronised cs high in any state SHALL return to IDLE within 1 clk; partially shifted write word discarded, memory unchanged.
REQ-024 sclk edges while cs is high SHALL be ignored.
REQ-025 Memory SHALL be single-port synchronous RAM, 1-clk read latency, no reset of contents.
REQ-026 Address increment at 2^ADDR_W-1 SHALL wrap to 0 with no error indication.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, counters 0, shift registers 0, miso 0, leds 0, synchronisers to idle values (sclk 1, cs 1, mosi 0).
REQ-028 Reset asserted mid-frame SHALL abort the frame with no memory write; after release the block waits for a fresh cs fall.

Structure
REQ-029 State enum and shared widths (counter width = clog2(max(ADDR_W+1, DATA_W))) SHALL live in package spi_mem_pkg.
REQ-030 Synchroniser plus edge detector SHALL be sub-module spi_sync_edge, instantiated once per SPI input.

Verification
REQ-031 Write 0xB1 to 0x61, then read 0x61 -> miso over 8 falls = 1,0,1,1,0,0,0,1; leds = 4'b0001.
REQ-032 Burst write 0xAA,0x55,0x3C starting at 0x7F in one frame -> reads give 0x7F=0xAA, 0x00=0x55, 0x01=0x3C.
REQ-033 Write 0x82 to 0x10 with cs raised after 11 of 16 bits -> 0x10 retains prior 0xB3.
REQ-034 Fill all 128 addresses with 0xB3, then 16-word burst read from 0x78 -> every word 0xB3, wrap 0x7F->0x00 seamless.
REQ-035 BURST_EN=0: 24-bit write frame (0x11 then 0x22) at 0x05 -> 0x05=0x11, 0x06 unchanged.
REQ-036 rst_n pulsed after 4 data bits of a write to 0x20 -> 0x20 unchanged, miso 0, leds 0; next frame operates normally.
